// File: rtl/player_input_checker.sv
// -----------------------------------------------------------------------------
// player_input_checker
//
// Player-input stage of the memory game. Synchronises and debounces the
// active-low tile keys, compares every accepted press against the expected
// tile of the packed sequence, enforces a per-press timeout and reports one
// PASS / WRONG / TIMEOUT result per round.
//
// Ports
//   clk            system clock, all state on posedge
//   resetn         asynchronous active-low reset
//   start          one-cycle pulse, begins (or restarts) a round
//   round_len      tiles to enter this round, sampled on start (clamped to MAX_LEN)
//   seq            packed sequence, tile i = seq[i*TILE_W +: TILE_W]
//   KEY            raw active-low pushbuttons (asynchronous)
//   busy           high from the cycle after start until done
//   tile_valid     one-cycle pulse per accepted press
//   tile_selected  index of the last accepted key, held between presses
//   input_idx      0-based position currently being entered
//   done           one-cycle pulse, round finished
//   result         01 PASS, 10 WRONG, 11 TIMEOUT; valid with done, held until start
// -----------------------------------------------------------------------------
module player_input_checker #(
    parameter int NUM_TILES = 4,
    parameter int TILE_W    = 2,
    parameter int MAX_LEN   = 32,
    parameter int LEN_W     = 6,
    parameter int DEBOUNCE  = 4,
    parameter int TIMEOUT   = 1000,
    parameter int TMR_W     = 10
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [LEN_W-1:0]          round_len,
    input  logic [MAX_LEN*TILE_W-1:0] seq,
    input  logic [NUM_TILES-1:0]      KEY,
    output logic                      busy,
    output logic                      tile_valid,
    output logic [TILE_W-1:0]         tile_selected,
    output logic [LEN_W-1:0]          input_idx,
    output logic                      done,
    output logic [1:0]                result
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_PASS    = 2'b01;
    localparam logic [1:0] RES_WRONG   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RELEASE,
        S_WAIT_PRESS,
        S_CHECK
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop key synchroniser
    // -------------------------------------------------------------------------
    logic [NUM_TILES-1:0] key_meta_q;
    logic [NUM_TILES-1:0] key_sync_q;

    // NOTE: the synchroniser resets to all-ones (keys released) so that the
    // first cycles after reset never look like a press; sequential state is
    // always written with non-blocking assignments.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registered state and outputs
    // -------------------------------------------------------------------------
    state_t             state_q;
    logic               busy_q;
    logic               tile_valid_q;
    logic [TILE_W-1:0]  tile_selected_q;
    logic [LEN_W-1:0]   input_idx_q;
    logic               done_q;
    logic [1:0]         result_q;
    logic [LEN_W-1:0]   len_q;
    logic [TMR_W-1:0]   timer_q;
    logic [DB_W-1:0]    db_cnt_q;
    logic [TILE_W-1:0]  cand_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [LEN_W-1:0]  start_len;
    logic              all_released;
    logic              cand_valid;
    logic [TILE_W-1:0] cand;
    logic [DB_W-1:0]   rel_cnt_d;
    logic [DB_W-1:0]   press_cnt_d;
    logic              release_ok;
    logic              press_accept;
    logic [TILE_W-1:0] seq_tile;

    assign start_len    = (round_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : round_len;
    assign all_released = &key_sync_q;

    // Lowest-index low key wins: scanning downwards lets the last hit stand.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        for (int k = NUM_TILES - 1; k >= 0; k--) begin
            if (!key_sync_q[k]) begin
                cand_valid = 1'b1;
                cand       = TILE_W'(k);
            end
        end
    end

    // One shared counter debounces both the release and the press phases;
    // it is cleared on every state change that uses it.
    always_comb begin
        rel_cnt_d   = '0;
        press_cnt_d = '0;
        if (all_released) begin
            rel_cnt_d = db_cnt_q + DB_W'(1);
        end
        if (cand_valid) begin
            // A different candidate restarts the stability count at one.
            if (db_cnt_q != '0 && cand == cand_q) begin
                press_cnt_d = db_cnt_q + DB_W'(1);
            end else begin
                press_cnt_d = DB_W'(1);
            end
        end
        release_ok   = all_released && (rel_cnt_d == DB_W'(DEBOUNCE));
        press_accept = cand_valid && (press_cnt_d == DB_W'(DEBOUNCE));
    end

    always_comb begin
        seq_tile = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (input_idx_q == LEN_W'(i)) begin
                seq_tile = seq[i*TILE_W +: TILE_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Round FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            tile_valid_q    <= 1'b0;
            tile_selected_q <= '0;
            input_idx_q     <= '0;
            done_q          <= 1'b0;
            result_q        <= RES_NONE;
            len_q           <= '0;
            timer_q         <= '0;
            db_cnt_q        <= '0;
            cand_q          <= '0;
        end else begin
            tile_valid_q <= 1'b0;
            done_q       <= 1'b0;

            // start has priority in every state: it silently aborts any round.
            if (start) begin
                len_q       <= start_len;
                input_idx_q <= '0;
                timer_q     <= '0;
                db_cnt_q    <= '0;
                if (start_len == '0) begin
                    done_q   <= 1'b1;
                    result_q <= RES_PASS;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end else begin
                    result_q <= RES_NONE;
                    busy_q   <= 1'b1;
                    state_q  <= S_WAIT_RELEASE;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                    end

                    S_WAIT_RELEASE: begin
                        if (release_ok) begin
                            state_q  <= S_WAIT_PRESS;
                            timer_q  <= '0;
                            db_cnt_q <= '0;
                        end else begin
                            db_cnt_q <= rel_cnt_d;
                        end
                    end

                    S_WAIT_PRESS: begin
                        // Acceptance is tested first so it wins over a
                        // simultaneous timeout.
                        if (press_accept) begin
                            tile_valid_q    <= 1'b1;
                            tile_selected_q <= cand;
                            db_cnt_q        <= '0;
                            state_q         <= S_CHECK;
                        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                            done_q   <= 1'b1;
                            result_q <= RES_TIMEOUT;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            timer_q  <= timer_q + TMR_W'(1);
                            db_cnt_q <= press_cnt_d;
                            cand_q   <= cand;
                        end
                    end

                    S_CHECK: begin
                        if (tile_selected_q != seq_tile) begin
                            done_q   <= 1'b1;
                            result_q <= RES_WRONG;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else if (input_idx_q == len_q - LEN_W'(1)) begin
                            done_q   <= 1'b1;
                            result_q <= RES_PASS;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            input_idx_q <= input_idx_q + LEN_W'(1);
                            db_cnt_q    <= '0;
                            state_q     <= S_WAIT_RELEASE;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign tile_valid    = tile_valid_q;
    assign tile_selected = tile_selected_q;
    assign input_idx     = input_idx_q;
    assign done          = done_q;
    assign result        = result_q;

endmodule

// File: tb/tb_player_input_checker.sv
// -----------------------------------------------------------------------------
// tb_player_input_checker
//
// Directed bench for player_input_checker with default parameters
// (NUM_TILES=4, DEBOUNCE=4, TIMEOUT=1000, MAX_LEN=32). Inputs are driven 1ns
// after the rising edge; outputs are observed at the same point. t_now counts
// rising edges since the last mark(), so the edge that samples start is t=1.
// -----------------------------------------------------------------------------
module tb_player_input_checker;

    localparam int NUM_TILES = 4;
    localparam int TILE_W    = 2;
    localparam int MAX_LEN   = 32;
    localparam int LEN_W     = 6;
    localparam int DEBOUNCE  = 4;
    localparam int TIMEOUT   = 1000;
    localparam int TMR_W     = 10;
    localparam int PRESS_LAT = 2 + DEBOUNCE;

    logic                      clk;
    logic                      resetn;
    logic                      start;
    logic [LEN_W-1:0]          round_len;
    logic [MAX_LEN*TILE_W-1:0] seq;
    logic [NUM_TILES-1:0]      KEY;
    logic                      busy;
    logic                      tile_valid;
    logic [TILE_W-1:0]         tile_selected;
    logic [LEN_W-1:0]          input_idx;
    logic                      done;
    logic [1:0]                result;

    player_input_checker #(
        .NUM_TILES (NUM_TILES),
        .TILE_W    (TILE_W),
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W),
        .DEBOUNCE  (DEBOUNCE),
        .TIMEOUT   (TIMEOUT),
        .TMR_W     (TMR_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .round_len     (round_len),
        .seq           (seq),
        .KEY           (KEY),
        .busy          (busy),
        .tile_valid    (tile_valid),
        .tile_selected (tile_selected),
        .input_idx     (input_idx),
        .done          (done),
        .result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation state, updated once per edge by tick().
    int                t_now;
    int                tv_seen;
    int                done_seen;
    int                tv_t;
    int                done_t;
    int                t_press;
    int                overlap = 0;
    logic [TILE_W-1:0] tv_sel;
    logic [LEN_W-1:0]  tv_idx;
    logic [1:0]        done_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t_now++;
        if (tile_valid) begin
            tv_seen++;
            tv_t   = t_now;
            tv_sel = tile_selected;
            tv_idx = input_idx;
        end
        if (done) begin
            done_seen++;
            done_t   = t_now;
            done_res = result;
        end
        if (done && tile_valid) overlap++;
    endtask

    task automatic mark();
        t_now     = 0;
        tv_seen   = 0;
        done_seen = 0;
        tv_t      = -1;
        done_t    = -1;
    endtask

    task automatic start_round(input int len);
        round_len = LEN_W'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Press key k for 'hold' cycles, then release for 8 cycles (enough for
    // the release debounce to reach WAIT_PRESS again).
    task automatic press_key(input int k, input int hold);
        t_press = t_now;
        KEY[k]  = 1'b0;
        repeat (hold) tick();
        KEY = '1;
        repeat (8) tick();
    endtask

    task automatic set_tile(input int i, input int v);
        seq[i*TILE_W +: TILE_W] = TILE_W'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tiles [3];
        exp_tiles = '{2, 0, 3};

        resetn    = 1'b0;
        start     = 1'b0;
        round_len = '0;
        seq       = '0;
        KEY       = '1;
        mark();
        #1;
        check("rst_busy", busy, 0);
        check("rst_tv", tile_valid, 0);
        check("rst_sel", tile_selected, 0);
        check("rst_idx", input_idx, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();

        // ---- PASS round: seq {2,0,3}, len 3 ----
        set_tile(0, 2); set_tile(1, 0); set_tile(2, 3);
        mark();
        start_round(3);
        check("pass_busy", busy, 1);
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            press_key(exp_tiles[i], 10);
            check("pass_tv_cnt", tv_seen, i + 1);
            check("pass_lat", tv_t - t_press, PRESS_LAT);
            check("pass_sel", tv_sel, exp_tiles[i]);
            check("pass_idx", tv_idx, i);
        end
        check("pass_done_cnt", done_seen, 1);
        check("pass_done_t", done_t, tv_t + 1);
        check("pass_result", done_res, 2'b01);
        check("pass_busy_end", busy, 0);

        // ---- WRONG round: presses 2,1 ----
        mark();
        start_round(3);
        repeat (5) tick();
        press_key(2, 10);
        press_key(1, 10);
        check("wrong_tv_cnt", tv_seen, 2);
        check("wrong_done_t", done_t, tv_t + 1);
        check("wrong_result", done_res, 2'b10);
        check("wrong_busy", busy, 0);
        check("wrong_idx", input_idx, 1);

        // ---- TIMEOUT: no key; WAIT_PRESS entered at edge 1+DEBOUNCE ----
        mark();
        start_round(2);
        while (done_seen == 0 && t_now < TIMEOUT + 100) tick();
        check("to_done_t", done_t, 1 + DEBOUNCE + TIMEOUT);
        check("to_result", done_res, 2'b11);
        check("to_busy", busy, 0);
        check("to_tv_cnt", tv_seen, 0);

        // ---- press accepted on the timeout cycle wins ----
        mark();
        start_round(2);
        while (t_now < 1 + DEBOUNCE + TIMEOUT - PRESS_LAT) tick();
        KEY[2] = 1'b0;
        while (t_now < 1 + DEBOUNCE + TIMEOUT + 4) tick();
        check("late_tv_t", tv_t, 1 + DEBOUNCE + TIMEOUT);
        check("late_no_done", done_seen, 0);
        check("late_idx", input_idx, 1);
        check("late_busy", busy, 1);

        // ---- KEY[1] held across a start that aborts the busy round ----
        KEY = 4'b1101;
        repeat (10) tick();
        mark();
        start_round(3);
        check("abort_idx", input_idx, 0);
        check("abort_busy", busy, 1);
        repeat (30) tick();
        check("held_no_tv", tv_seen, 0);
        check("abort_no_done", done_seen, 0);
        KEY = '1;
        repeat (8) tick();
        press_key(1, 10);
        check("held_tv_cnt", tv_seen, 1);
        check("held_lat", tv_t - t_press, PRESS_LAT);
        check("held_sel", tv_sel, 1);
        check("held_result", done_res, 2'b10);

        // ---- KEY[0] and KEY[3] together: lowest index wins ----
        mark();
        start_round(3);
        repeat (5) tick();
        t_press = t_now;
        KEY = 4'b0110;
        repeat (10) tick();
        KEY = '1;
        repeat (8) tick();
        check("multi_sel", tv_sel, 0);
        check("multi_lat", tv_t - t_press, PRESS_LAT);

        // ---- glitches shorter than DEBOUNCE are ignored ----
        mark();
        start_round(3);
        repeat (5) tick();
        press_key(2, 2);
        check("glitch2_no_tv", tv_seen, 0);
        press_key(2, DEBOUNCE - 1);
        check("glitch3_no_tv", tv_seen, 0);
        press_key(2, DEBOUNCE);
        check("hold4_tv", tv_seen, 1);
        check("hold4_sel", tv_sel, 2);

        // ---- round_len 0: PASS one cycle after start ----
        mark();
        start_round(0);
        check("len0_done", done, 1);
        check("len0_result", result, 2'b01);
        check("len0_busy", busy, 0);
        tick();
        check("len0_single", done_seen, 1);

        // ---- round_len 40 clamps to MAX_LEN ----
        for (int i = 0; i < MAX_LEN; i++) set_tile(i, (i * 3 + 2) % 4);
        mark();
        start_round(40);
        repeat (5) tick();
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i == MAX_LEN - 1) check("len40_no_early", done_seen, 0);
            press_key((i * 3 + 2) % 4, 10);
        end
        check("len40_tv_cnt", tv_seen, MAX_LEN);
        check("len40_done_cnt", done_seen, 1);
        check("len40_done_t", done_t, tv_t + 1);
        check("len40_result", done_res, 2'b01);
        check("len40_idx", input_idx, MAX_LEN - 1);

        // ---- asynchronous reset mid-round ----
        mark();
        start_round(3);
        repeat (5) tick();
        press_key(2, 10);
        check("rst2_idx_pre", input_idx, 1);
        KEY[0] = 1'b0;
        repeat (2) tick();
        #2;
        resetn = 1'b0;
        #1;
        check("rst2_busy", busy, 0);
        check("rst2_idx", input_idx, 0);
        check("rst2_sel", tile_selected, 0);
        check("rst2_result", result, 0);
        check("rst2_done", done, 0);
        check("rst2_tv", tile_valid, 0);
        tick();
        resetn = 1'b1;
        mark();
        repeat (20) tick();
        check("rst2_no_done", done_seen, 0);
        check("rst2_no_tv", tv_seen, 0);
        KEY = '1;
        repeat (4) tick();

        check("no_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_input_checker.md
# player_input_checker

Parametrised player-input stage for the memory game. It takes the packed tile sequence and round length from the sequence generator and synchronises and debounces the active-low tile keys. It compares each accepted press against the expected tile, enforces a per-press timeout, and reports one pass/wrong/timeout result per round to the game controller.

## Interface
- NUM_TILES, 4, number of keys/tiles (2..16)
- TILE_W, 2, tile index width; 2**TILE_W >= NUM_TILES
- MAX_LEN, 32, maximum sequence length
- LEN_W, 6, width of round_len/input_idx; 2**LEN_W > MAX_LEN
- DEBOUNCE, 4, consecutive stable cycles required for a press or a release (>=1)
- TIMEOUT, 1000, cycles allowed in WAIT_PRESS before a timeout (>=2)
- TMR_W, 10, timer width; 2**TMR_W >= TIMEOUT
- clk  in  1  system clock; all state on posedge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins (or restarts) a round
- round_len  in  LEN_W  tiles to enter this round; sampled on start
- seq  in  MAX_LEN*TILE_W  packed sequence; tile i = seq[i*TILE_W +: TILE_W]; must be held stable while busy
- KEY  in  NUM_TILES  raw pushbuttons, active-low, asynchronous
- busy  out  1  high from the cycle after start until done
- tile_valid  out  1  one-cycle pulse per accepted press
- tile_selected  out  TILE_W  index of last accepted key; valid with tile_valid and held afterwards
- input_idx  out  LEN_W  position being entered (0-based)
- done  out  1  one-cycle pulse; round finished
- result  out  2  valid with done and held until next start: 01 PASS, 10 WRONG, 11 TIMEOUT

## Operation
- KEY passes through a 2-flop synchroniser; only the synchronised value is used.
- States: IDLE, WAIT_RELEASE, WAIT_PRESS, CHECK.
- IDLE: on start, latch len = min(round_len, MAX_LEN), clear input_idx and timer, clear result to 00, set busy, and go to WAIT_RELEASE. If len == 0, pulse done with PASS on the next cycle and return to IDLE.
- WAIT_RELEASE: wait until all synchronised keys have been high for DEBOUNCE consecutive cycles, then go to WAIT_PRESS with the timer cleared. No timeout runs in this state. A key held from a previous round is therefore never accepted.
- WAIT_PRESS:
  - The timer increments every cycle.
  - A candidate is the lowest-index low key. It must remain the lowest-index low key for DEBOUNCE consecutive cycles; a change of candidate restarts the count.
  - On acceptance: pulse tile_valid, load tile_selected, and go to CHECK.
  - When the timer reaches TIMEOUT-1 without acceptance: pulse done with TIMEOUT, clear busy, go to IDLE.
  - If acceptance and timeout occur in the same cycle, acceptance wins.
- CHECK (one cycle):
  - tile_selected != seq tile[input_idx]: done with WRONG, go to IDLE.
  - Match and input_idx == len-1: done with PASS, go to IDLE.
  - Otherwise: input_idx increments, go to WAIT_RELEASE.
- start while busy aborts the current round with no done pulse and restarts as from IDLE in the same cycle.
- resetn low at any time forces IDLE immediately.
- Reset values of all outputs and registers are 0: busy, tile_valid, tile_selected, input_idx, done, result, timer, debounce count.

## Timing
- Press latency: KEY[k] low from before edge t and held stable → tile_valid high in the cycle after edge t+1+DEBOUNCE, i.e. 2 synchroniser cycles plus DEBOUNCE.
- The CHECK decision (done or idx++) lands exactly one cycle after tile_valid.
- done and tile_valid are never high in the same cycle. done is never repeated for one round.
- busy falls in the same cycle that done is high.
- Release-to-ready: all keys high → WAIT_PRESS entered 2+DEBOUNCE cycles later.
- Minimum cycles per tile: 2*(2+DEBOUNCE)+1.
- tile_valid is never high in IDLE.

## Test plan
- seq tiles {2,0,3}, round_len=3, presses 2,0,3 each held 10 cycles with releases between → three tile_valid pulses with input_idx 0,1,2; done with result=01 one cycle after the third tile_valid.
- Same seq, presses 2,1 → done with result=10 one cycle after the second tile_valid; busy=0; input_idx=1.
- round_len=2, no keys pressed → done with result=11 exactly TIMEOUT cycles after entering WAIT_PRESS. Repeat with a press accepted on the final cycle → no timeout.
- KEY[1] held continuously across a start → no tile_valid until it is released for DEBOUNCE cycles and pressed again. KEY[0] and KEY[3] pressed together → tile_selected=0. A 2-cycle glitch on KEY[2] with DEBOUNCE=4 → no tile_valid.
- round_len=0 → done with PASS one cycle after start. round_len=40 with MAX_LEN=32 → round completes after 32 correct presses.
- resetn asserted mid-round → all outputs 0 asynchronously; after release no done appears. start mid-round → input_idx returns to 0 and no done is emitted for the aborted round.
